// File: rtl/soft_reset_gen.sv
// soft_reset_gen: request/acknowledge soft-reset sequencer producing a registered auxiliary reset pulse.
// Optional watchdog trigger is built only when SOFT_RST_WDT_EN is defined.
module soft_reset_gen #(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned HOLDOFF_CYCLES = 32,
  parameter int unsigned WDT_CYCLES     = 1048576
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       i_req,
  output logic       o_ack,
  input  logic       i_sys_resetn_sync,
  output logic       o_aux_resetn,
  output logic       o_busy,
  output logic [1:0] o_cause,
  input  logic       i_wdt_en,
  input  logic       i_wdt_kick
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CAUSE_W = 2;
  localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CONFIRM_LAST = CNT_W'(254);
  localparam logic [CAUSE_W-1:0] CAUSE_SOFT   = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_WDT    = CAUSE_W'(2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_CONFIRM = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 r_ack;
  logic                 w_ack_nxt;
  logic                 r_aux_resetn;
  logic                 r_busy;
  logic [CAUSE_W-1:0]   r_cause;
  logic [CAUSE_W-1:0]   w_cause_nxt;
  logic                 w_wdt_fire;

  // State and output registers; outputs are derived from the next state so they change only on edges.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ack        <= 1'b0;
      r_aux_resetn <= 1'b1;
      r_busy       <= 1'b0;
      r_cause      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ack        <= w_ack_nxt;
      r_aux_resetn <= (w_state_nxt != S_ASSERT);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_cause      <= w_cause_nxt;
    end
  end

  // Next-state logic; one shared counter is cleared on every state change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_wdt_fire) begin
          w_state_nxt = S_ASSERT;
          w_cause_nxt = CAUSE_WDT;
        end else if (i_req) begin
          w_state_nxt = S_ASSERT;
          w_ack_nxt   = 1'b1;
          w_cause_nxt = CAUSE_SOFT;
        end
      end
      S_ASSERT: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = S_CONFIRM;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CONFIRM: begin
        if (i_sys_resetn_sync || (r_cnt == CONFIRM_LAST)) begin
          w_state_nxt = S_HOLDOFF;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == HOLDOFF_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef SOFT_RST_WDT_EN
  localparam int unsigned        WDT_W    = 24;
  localparam logic [WDT_W-1:0]   WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] r_wdt_cnt;

  // A kick in the expiry cycle suppresses the trigger.
  assign w_wdt_fire = (r_state == S_IDLE) && i_wdt_en && !i_wdt_kick && (r_wdt_cnt == WDT_LAST);

  // Watchdog counts only in IDLE, clears on kick/disable/entry to ASSERT, holds elsewhere.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wdt_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_wdt_kick || !i_wdt_en || (w_state_nxt == S_ASSERT)) begin
        r_wdt_cnt <= '0;
      end else begin
        r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
      end
    end
  end
`else
  logic w_unused;

  assign w_wdt_fire = 1'b0;
  assign w_unused   = &{1'b0, i_wdt_en, i_wdt_kick, WDT_CYCLES[0]};
`endif

  assign o_ack        = r_ack;
  assign o_aux_resetn = r_aux_resetn;
  assign o_busy       = r_busy;
  assign o_cause      = r_cause;

endmodule

// File: doc/soft_reset_gen.md
SOFT_RESET_GEN -- requirements
Module: soft_reset_gen

Interface
REQ-001 Parameter PULSE_CYCLES, default 4: number of cycles o_aux_resetn is held low per soft reset (legal range 1..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 32: cooldown cycles after system reset release before a new request is accepted (legal range 1..255).
REQ-003 Parameter WDT_CYCLES, default 1048576: watchdog expiry count (legal range 2..2^24); used only when SOFT_RST_WDT_EN is defined.
REQ-004 clk  input  1  clock; the only clock.
REQ-005 aresetn  input  1  asynchronous active-low reset; driven from the Loader x2 reset, never from the system reset this block generates.
REQ-006 i_req  input  1  soft-reset request level; the requester holds it until o_ack.
REQ-007 o_ack  output  1  one-cycle pulse, request accepted.
REQ-008 i_sys_resetn_sync  input  1  feedback from the x4 stretched system reset (active-low).
REQ-009 o_aux_resetn  output  1  auxiliary reset to the reset controller; registered, glitch-free.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_cause  output  2  last reset cause: 00 none, 01 soft, 10 watchdog, 11 reserved; sticky.
REQ-012 i_wdt_en  input  1  watchdog enable (WDT build only; otherwise ignored).
REQ-013 i_wdt_kick  input  1  watchdog restart pulse (WDT build only; otherwise ignored).

Function
REQ-014 FSM states: IDLE, ASSERT, CONFIRM, HOLDOFF; state encoding is registered.
REQ-015 IDLE->ASSERT when i_req=1 is sampled at edge T: o_aux_resetn=0 and o_ack=1 in cycle T+1, o_cause=01.
REQ-016 ASSERT: an 8-bit counter holds o_aux_resetn low for exactly PULSE_CYCLES cycles, then ->CONFIRM with o_aux_resetn=1.
REQ-017 CONFIRM: wait until i_sys_resetn_sync=1, then ->HOLDOFF; an 8-bit timeout of 255 cycles also forces ->HOLDOFF.
REQ-018 HOLDOFF: count HOLDOFF_CYCLES cycles, then ->IDLE.
REQ-019 i_req while o_busy=1 is ignored: no ack, no queueing; a request still held on return to IDLE is accepted on the next cycle.
REQ-020 o_ack is never high for more than one consecutive cycle.
REQ-021 o_aux_resetn changes only on clk edges; o_aux_resetn=0 only in ASSERT.
REQ-022 o_cause updates only on entry to ASSERT and holds its value otherwise.

Reset
REQ-023 On aresetn=0, asynchronously: state=IDLE, o_aux_resetn=1, o_ack=0, o_busy=0, o_cause=00, all counters=0.
REQ-024 aresetn asserted mid-ASSERT aborts the pulse; o_aux_resetn returns to 1 immediately.
REQ-025 Deassertion of aresetn is synchronous to clk; the first request can be accepted on the first edge after release.

Configuration
REQ-026 Macro SOFT_RST_WDT_EN: when defined, a 24-bit watchdog counter increments each cycle in IDLE while i_wdt_en=1.
REQ-027 With SOFT_RST_WDT_EN, i_wdt_kick or i_wdt_en=0 clears the counter; kick wins over expiry in the same cycle.
REQ-028 With SOFT_RST_WDT_EN, count reaching WDT_CYCLES-1 triggers IDLE->ASSERT with o_cause=10 and no o_ack; expiry beats a simultaneous i_req, which stays pending.
REQ-029 With SOFT_RST_WDT_EN, the watchdog counter clears on entry to ASSERT and holds outside IDLE.
REQ-030 Without SOFT_RST_WDT_EN, no watchdog logic is built, i_wdt_en/i_wdt_kick are unused, and o_cause is never 10.

Verification
REQ-031 Defaults; i_req=1 at edge 10 -> o_ack at cycle 11, o_aux_resetn low cycles 11-14, o_cause=01, o_busy=1.
REQ-032 Feedback i_sys_resetn_sync rises 6 cycles after pulse end -> HOLDOFF 32 cycles; o_busy falls exactly 38 cycles after pulse end.
REQ-033 i_req pulsed during HOLDOFF and dropped before IDLE -> no o_ack, no second pulse.
REQ-034 i_sys_resetn_sync held 0 -> CONFIRM times out after 255 cycles, then HOLDOFF, then IDLE.
REQ-035 aresetn=0 on the 2nd ASSERT cycle -> o_aux_resetn=1 immediately, o_cause=00, state IDLE after release.
REQ-036 WDT build, WDT_CYCLES=100, i_wdt_en=1, no kick -> o_aux_resetn low after 100 cycles, o_cause=10; kick every 50 cycles -> no reset.
